// File: rtl/matmul_seq_nxn.sv
// Sequential NxN unsigned matrix multiplier C = A*B: nibble-wide element load, one MAC per clock, acknowledged drain.
// Optional MATMUL_ACCUM_EN build lets a pass accumulate (saturating) onto the retained C.
module matmul_seq_nxn #(
   parameter int N  = 2,
   parameter int EW = 2
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam int RW = 2*EW + $clog2(N);
   localparam int NN = N*N;
   localparam int IW = $clog2(N);
   localparam int XW = $clog2(NN);
   localparam int LW = $clog2(2*NN);

   if (N < 2 || N > 4 || EW < 1 || EW > 4 || RW > 6) begin : g_bad_params
      $error("matmul_seq_nxn: illegal N/EW combination");
   end

   typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

   logic          clk;
   logic          rst;
   logic          stb;
   logic [EW-1:0] din;
   logic          unused_in;

   assign clk       = io_in[0];
   assign rst       = io_in[1];
   assign stb       = io_in[2];
   assign din       = io_in[3+EW:4];
   assign unused_in = ^io_in;

   state_t        state, state_next;
   logic [EW-1:0] a [NN];
   logic [EW-1:0] b [NN];
   logic [RW-1:0] c [NN];
   logic [LW-1:0] ld_idx;
   logic [XW-1:0] dr_idx;
   logic [IW-1:0] i, j, k;

   logic          last_load, last_mac, last_drain;
   logic [XW-1:0] a_sel, b_sel, c_sel, b_ld;
   logic [RW-1:0] prod, base, c_new;
   logic [RW:0]   sum;

`ifdef MATMUL_ACCUM_EN
   logic acc_q;

   function automatic logic [RW-1:0] sat(input logic [RW:0] s);
      return s[RW] ? {RW{1'b1}} : s[RW-1:0];
   endfunction
`endif

   assign last_load  = stb && (ld_idx == LW'(2*NN-1));
   assign last_drain = stb && (dr_idx == XW'(NN-1));
   assign last_mac   = (i == IW'(N-1)) && (j == IW'(N-1)) && (k == IW'(N-1));

   assign a_sel = XW'(i) * XW'(N) + XW'(k);
   assign b_sel = XW'(k) * XW'(N) + XW'(j);
   assign c_sel = XW'(i) * XW'(N) + XW'(j);
   assign b_ld  = XW'(ld_idx - LW'(NN));

   // The k=0 term starts a fresh dot product unless this pass accumulates onto C.
`ifdef MATMUL_ACCUM_EN
   assign base  = (k == '0 && !acc_q) ? '0 : c[c_sel];
`else
   assign base  = (k == '0) ? '0 : c[c_sel];
`endif
   assign prod  = RW'(a[a_sel]) * RW'(b[b_sel]);
   assign sum   = {1'b0, base} + {1'b0, prod};
`ifdef MATMUL_ACCUM_EN
   assign c_new = sat(sum);
`else
   assign c_new = sum[RW-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      io_out     = 8'h00;
      case (state)
         LOAD: begin
            io_out[7] = 1'b1;
            if (last_load) state_next = COMPUTE;
         end
         COMPUTE: begin
            if (last_mac) state_next = DRAIN;
         end
         DRAIN: begin
            io_out[6]   = 1'b1;
            io_out[5:0] = 6'(c[dr_idx]);
            if (last_drain) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NN; n++) begin
            a[n] <= '0;
            b[n] <= '0;
            c[n] <= '0;
         end
         ld_idx <= '0;
         dr_idx <= '0;
         i      <= '0;
         j      <= '0;
         k      <= '0;
`ifdef MATMUL_ACCUM_EN
         acc_q  <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               if (stb) begin
                  if (ld_idx < LW'(NN)) a[ld_idx[XW-1:0]] <= din;
                  else                  b[b_ld]           <= din;
`ifdef MATMUL_ACCUM_EN
                  if (ld_idx == '0) acc_q <= io_in[3];
`endif
                  ld_idx <= last_load ? '0 : ld_idx + LW'(1);
               end
            end
            COMPUTE: begin
               c[c_sel] <= c_new;
               // Loop order i outer, j middle, k inner; all wrap to 0 after the final MAC.
               if (k == IW'(N-1)) begin
                  k <= '0;
                  if (j == IW'(N-1)) begin
                     j <= '0;
                     i <= (i == IW'(N-1)) ? '0 : i + IW'(1);
                  end else begin
                     j <= j + IW'(1);
                  end
               end else begin
                  k <= k + IW'(1);
               end
            end
            DRAIN: begin
               if (stb) dr_idx <= last_drain ? '0 : dr_idx + XW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq_nxn.sv
// Directed bench for matmul_seq_nxn: N=2/EW=2 hand-computed vectors plus N=3/EW=2 and N=4/EW=1 random
// matrices against a software model; the accumulate section follows MATMUL_ACCUM_EN.
module tb_matmul_seq_nxn;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       acc_v = 1'b0;
   logic       stb_v [3];
   logic [3:0] dat_v [3];
   logic [7:0] in_v  [3];
   logic [7:0] out_v [3];
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   assign in_v[0] = {dat_v[0], acc_v, stb_v[0], rst, clk};
   assign in_v[1] = {dat_v[1], 1'b0,  stb_v[1], rst, clk};
   assign in_v[2] = {dat_v[2], 1'b0,  stb_v[2], rst, clk};

   matmul_seq_nxn #(.N(2), .EW(2)) dut2 (.io_in(in_v[0]), .io_out(out_v[0]));
   matmul_seq_nxn #(.N(3), .EW(2)) dut3 (.io_in(in_v[1]), .io_out(out_v[1]));
   matmul_seq_nxn #(.N(4), .EW(1)) dut4 (.io_in(in_v[2]), .io_out(out_v[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Returns at the falling edge just after the edge that sampled the final load beat.
   task automatic load(input int s, input int n, input int ew, input int m[$],
                       input int first, input int idle, input logic accv);
      for (int bt = first; bt < 2*n*n; bt++) begin
         @(negedge clk);
         stb_v[s] = 1'b1;
         dat_v[s] = 4'(m[bt]) | (4'($urandom) & ~4'((1 << ew) - 1));
         if (s == 0) acc_v = (bt == 0) ? accv : 1'b0;
         if (idle > 0 && bt != 2*n*n-1) begin
            @(negedge clk);
            stb_v[s] = 1'b0;
            repeat (idle-1) @(negedge clk);
         end
      end
      @(negedge clk);
      stb_v[s] = 1'b0;
      acc_v    = 1'b0;
   endtask

   task automatic run(input int s, input int n, input int ew, input int m[$], input int e[$],
                      input int first, input int idle, input logic accv,
                      input int hold0, input int hold_last);
      int cyc;
      load(s, n, ew, m, first, idle, accv);
      check("ready_low_after_load", 32'(out_v[s][7]), 0);
      cyc = 0;
      while (out_v[s][6] !== 1'b1 && cyc < 200) begin
         check("no_output_in_compute", 32'(out_v[s]), 0);
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, n*n*n);
      repeat (hold0) begin
         check("drain_hold", 32'(out_v[s][5:0]), e[0]);
         @(negedge clk);
      end
      for (int x = 0; x < n*n; x++) begin
         check("result", 32'(out_v[s][5:0]), e[x]);
         check("out_valid", 32'(out_v[s][7:6]), 1);
         stb_v[s] = 1'b1;
         @(negedge clk);
      end
      check("back_to_load", 32'(out_v[s]), 32'h80);
      if (hold_last >= 0) begin
         dat_v[s] = 4'(hold_last);
         @(negedge clk);
      end
      stb_v[s] = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ma[$], mb[$], m3[$], mi[$], ea[$], e18[$], e31[$], ei[$], mr[$], er[$];
      int nn, ew;
      for (int s = 0; s < 3; s++) begin stb_v[s] = 1'b0; dat_v[s] = 4'h0; end
      ma  = '{1, 2, 3, 0, 2, 1, 1, 3};
      ea  = '{4, 7, 6, 3};
      m3  = '{3, 3, 3, 3, 3, 3, 3, 3};
      e18 = '{18, 18, 18, 18};
      e31 = '{31, 31, 31, 31};
      mi  = '{1, 0, 0, 1, 1, 2, 3, 0};
      ei  = '{1, 2, 3, 0};

      #1;
      check("reset_out_n2", 32'(out_v[0]), 32'h80);
      check("reset_out_n3", 32'(out_v[1]), 32'h80);
      check("reset_out_n4", 32'(out_v[2]), 32'h80);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 32'(out_v[0]), 32'h80);

      // Basic multiply with drain hold, then stb held through the final advance.
      run(0, 2, 2, ma, ea, 0, 0, 1'b0, 5, 1);
      // A[0][0]=1 was taken by the held strobe; the remaining seven beats complete the pass.
      run(0, 2, 2, ma, ea, 1, 0, 1'b0, 0, -1);

      run(0, 2, 2, m3, e18, 0, 0, 1'b0, 0, -1);
      run(0, 2, 2, m3, e18, 0, 2, 1'b0, 0, -1);

      // Reset mid-COMPUTE aborts immediately, then a normal pass follows.
      load(0, 2, 2, ma, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("mid_compute_out", 32'(out_v[0]), 0);
      rst = 1'b1;
      #1;
      check("reset_mid_compute", 32'(out_v[0]), 32'h80);
      @(negedge clk);
      check("reset_held", 32'(out_v[0]), 32'h80);
      rst = 1'b0;
      run(0, 2, 2, ma, ea, 0, 0, 1'b0, 0, -1);

`ifdef MATMUL_ACCUM_EN
      run(0, 2, 2, m3, e18, 0, 0, 1'b0, 0, -1);
      run(0, 2, 2, m3, e31, 0, 0, 1'b1, 0, -1);
      run(0, 2, 2, mi, ei, 0, 0, 1'b0, 0, -1);
`else
      run(0, 2, 2, m3, e18, 0, 0, 1'b0, 0, -1);
      run(0, 2, 2, m3, e18, 0, 0, 1'b1, 0, -1);
      run(0, 2, 2, mi, ei, 0, 0, 1'b1, 0, -1);
`endif

      for (int s = 1; s < 3; s++) begin
         nn = s + 2;
         ew = (s == 1) ? 2 : 1;
         for (int t = 0; t < 100; t++) begin
            mr.delete();
            er.delete();
            for (int q = 0; q < 2*nn*nn; q++) mr.push_back(int'($urandom_range(0, (1 << ew) - 1)));
            for (int r = 0; r < nn; r++)
               for (int c = 0; c < nn; c++) begin
                  int acc_sum;
                  acc_sum = 0;
                  for (int q = 0; q < nn; q++) acc_sum += mr[r*nn+q] * mr[nn*nn + q*nn + c];
                  er.push_back(acc_sum);
               end
            run(s, nn, ew, mr, er, 0, t % 2, 1'b0, 0, -1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/matmul_seq_nxn.md
# matmul_seq_nxn

Sequential, parametrised N×N integer matrix multiplier for an 8-pin user slot: C = A·B with EW-bit unsigned elements. Elements stream in one per clock through a 4-bit data nibble. The block computes one multiply-accumulate per cycle, then presents the N² results one per acknowledge beat. It is the clocked, multi-bit, variable-dimension successor to the 2×2 binary combinational multiplier in the same slot family.

## Interface
Parameters:
- N, default 2: matrix dimension; legal values 2..4.
- EW, default 2: element width in bits; legal values 1..4.
- RW, derived as 2·EW + clog2(N): result width.
- Legal combinations: RW ≤ 6 (for example N=2/EW=2 → RW=5, N=3/EW=2 → RW=6, N=4/EW=1 → RW=4). An illegal combination is an elaboration error.

Ports:
- io_in[0], input, 1: clk. One clock; all state on its rising edge.
- io_in[1], input, 1: reset. Asynchronous, active-high.
- io_in[2], input, 1: stb. Load strobe in LOAD; read-advance in DRAIN.
- io_in[3], input, 1: acc. Accumulate select; used only with MATMUL_ACCUM_EN.
- io_in[7:4], input, 4: data nibble. The element is io_in[3+EW:4]; upper bits are ignored.
- io_out[5:0], output, 6: result C[idx], zero-extended; 0 outside DRAIN.
- io_out[6], output, 1: out_valid; high in DRAIN only.
- io_out[7], output, 1: ready; high in LOAD only.

## Operation
- Storage:
  - A and B: N² EW-bit registers each.
  - C: N² RW-bit registers.
  - Counters: load index 0..2N²−1, loop indices i, j, k, drain index 0..N²−1.
- State LOAD:
  - Each clock with stb=1 writes the element to A (beats 0..N²−1, row-major) or to B (beats N²..2N²−1, row-major).
  - stb=0 holds all state.
  - The beat with index 2N²−1 moves the state to COMPUTE.
- State COMPUTE:
  - One MAC per cycle, loop order i outer, j middle, k inner.
  - At k=0: C[i][j] ← A[i][0]·B[0][j]. This is overridden in accumulate mode (see Configuration).
  - At k>0: C[i][j] ← C[i][j] + A[i][k]·B[k][j].
  - stb is ignored. The MAC at i=j=k=N−1 moves the state to DRAIN.
- State DRAIN:
  - Drain index starts at 0; io_out[5:0] = C[idx], row-major.
  - Each clock with stb=1 advances the index.
  - stb=1 at idx=N²−1 returns the state to LOAD and clears the load index. C is retained.
- No overflow is possible in the non-accumulating path, by the choice of RW.

## Timing
- Reset (async assert) sets state LOAD and clears all counters, A, B and C.
- Output values while reset is asserted and after it: io_out = 8'b1000_0000.
- Reset asserted mid-LOAD, mid-COMPUTE or mid-DRAIN aborts the operation immediately. Partial data is discarded and no output glitches to out_valid=1.
- LOAD takes 2N² stb beats; idle cycles may be interleaved freely.
- Latency: if the last load beat is sampled at edge t, ready falls after t and out_valid rises after edge t+N³ (8 cycles for N=2). In COMPUTE, ready=0 and out_valid=0.
- In DRAIN, result bits change only on the edge that samples stb=1. ready rises after the edge that samples the final stb.
- A stb held high across the LOAD→COMPUTE boundary causes no extra write. A stb held high across DRAIN→LOAD loads element A[0][0] only on the first edge after ready=1.

## Configuration
- Macro: MATMUL_ACCUM_EN.
- Defined:
  - acc is sampled together with load beat 0. If acc=1, the k=0 MAC of that pass becomes C[i][j] ← C[i][j] + A[i][0]·B[0][j], so the pass accumulates onto the retained C.
  - Every accumulate saturates at 2^RW−1.
  - acc=0 behaves as the non-accumulating path.
- Undefined: acc is ignored, there is no saturation logic, and C is always overwritten.

## Test plan
- Reset value: assert reset mid-COMPUTE → io_out=8'h80 immediately; load and compute proceed normally after release.
- Basic multiply (N=2, EW=2): A=[[1,2],[3,0]], B=[[2,1],[1,3]] → drained sequence 4, 7, 6, 3. out_valid rises exactly 8 clocks after the last load beat.
- Maximum values: all elements 3 → four results of 18. Idle cycles (stb=0) inserted between load beats → identical result.
- Drain handshake: hold stb=0 for 5 cycles in DRAIN → result holds at 4. stb held high through the last advance → ready=1 next cycle and exactly one element loaded.
- Accumulate (MATMUL_ACCUM_EN defined): the all-3 pass, then a second all-3 pass with acc=1 → results 31 (saturated from 36). A third pass with acc=0 and A=I, B=[[1,2],[3,0]] → 1, 2, 3, 0.
- Parameter sweep: N=3/EW=2 and N=4/EW=1 against a software model, 100 random matrices each → all results match and latency equals N³.
